unroll_oc_sched: RTL and testbench

Pass scheduler for the `unroll_oc` convolution engine. It accepts one layer job over a configuration handshake and walks the output tile grid and the kernel positions. For each (tile, kh, kw) combination it issues one `unroll_oc` pass: it drives the pass parameters, pulses `start`, waits for `done`, then advances. It sits between the layer-level controller and `unroll_oc`. It also reports accumulator-clear, tile-completion and job-completion events for the output-buffer drain logic.

---
 rtl/unroll_oc_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_unroll_oc_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unroll_oc_sched.sv
// unroll_oc_sched: pass scheduler for the unroll_oc convolution engine.
// Accepts one layer job, then walks tile rows/cols and kernel rows/cols
// (kw innermost, th outermost), issuing one unroll_oc pass per combination
// and reporting accumulator-clear, tile-done and job-done events.
module unroll_oc_sched #(
  parameter int IC_WIDTH        = 5,
  parameter int TILE_SIZE_WIDTH = 5,
  parameter int TILE_CNT_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [IC_WIDTH-1:0]        cfg_ic_last,
  input  logic [1:0]                 cfg_kh_last,
  input  logic [1:0]                 cfg_kw_last,
  input  logic [TILE_CNT_WIDTH-1:0]  cfg_th_last,
  input  logic [TILE_CNT_WIDTH-1:0]  cfg_tw_last,
  input  logic [TILE_SIZE_WIDTH-1:0] cfg_ih_last_full,
  input  logic [TILE_SIZE_WIDTH-1:0] cfg_iw_last_full,
  input  logic [TILE_SIZE_WIDTH-1:0] cfg_ih_last_edge,
  input  logic [TILE_SIZE_WIDTH-1:0] cfg_iw_last_edge,
  input  logic                       abort,
  output logic                       start,
  input  logic                       done,
  output logic [IC_WIDTH-1:0]        ic_last,
  output logic [TILE_SIZE_WIDTH-1:0] ih_low_start,
  output logic [TILE_SIZE_WIDTH-1:0] iw_low_start,
  output logic [TILE_SIZE_WIDTH-1:0] ih_low_last,
  output logic [TILE_SIZE_WIDTH-1:0] iw_low_last,
  output logic [1:0]                 kh,
  output logic [1:0]                 kw,
  output logic [TILE_CNT_WIDTH-1:0]  tile_h,
  output logic [TILE_CNT_WIDTH-1:0]  tile_w,
  output logic                       acc_clear,
  output logic                       tile_done,
  output logic                       job_done,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched job descriptor (ic_last is held directly on its output register)
  logic [1:0]                 kh_last_q;
  logic [1:0]                 kw_last_q;
  logic [TILE_CNT_WIDTH-1:0]  th_last_q;
  logic [TILE_CNT_WIDTH-1:0]  tw_last_q;
  logic [TILE_SIZE_WIDTH-1:0] ih_full_q;
  logic [TILE_SIZE_WIDTH-1:0] iw_full_q;
  logic [TILE_SIZE_WIDTH-1:0] ih_edge_q;
  logic [TILE_SIZE_WIDTH-1:0] iw_edge_q;

  logic done_q;
  logic done_rise;
  logic accept;
  logic advance;

  logic kw_at_last;
  logic kh_at_last;
  logic tw_at_last;
  logic th_at_last;
  logic tile_last;
  logic job_last;

  logic [1:0]                kw_nx;
  logic [1:0]                kh_nx;
  logic [TILE_CNT_WIDTH-1:0] tw_nx;
  logic [TILE_CNT_WIDTH-1:0] th_nx;

  // A done that is already high when WAIT begins must fall and rise again
  // before it counts, so only the 0->1 transition is used.
  assign done_rise = done & ~done_q;

  // abort outranks an accepting cfg_valid in IDLE
  assign accept  = (state_q == S_IDLE) && cfg_valid && !abort;

  assign kw_at_last = (kw == kw_last_q);
  assign kh_at_last = (kh == kh_last_q);
  assign tw_at_last = (tile_w == tw_last_q);
  assign th_at_last = (tile_h == th_last_q);
  assign tile_last  = kw_at_last && kh_at_last;
  assign job_last   = tile_last && tw_at_last && th_at_last;

  // Counters step in NEXT unless this was the final pass (no wrap past last)
  assign advance = (state_q == S_NEXT) && !abort && !job_last;

  // Passes always cover the tile from its first row/column
  assign ih_low_start = '0;
  assign iw_low_start = '0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (cfg_valid) state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  if (done_rise) state_d = S_NEXT;
        S_NEXT:  state_d = job_last ? S_IDLE : S_ISSUE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; event pulses are suppressed in an abort cycle
  always_comb begin
    cfg_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    start     = (state_q == S_ISSUE) && !abort;
    tile_done = (state_q == S_NEXT) && !abort && tile_last;
    job_done  = (state_q == S_NEXT) && !abort && job_last;
  end

  // Registered done for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

  // Odometer increment: kw innermost, then kh, tile_w, tile_h
  always_comb begin
    kw_nx = kw;
    kh_nx = kh;
    tw_nx = tile_w;
    th_nx = tile_h;
    if (!kw_at_last) begin
      kw_nx = kw + 2'd1;
    end else begin
      kw_nx = '0;
      if (!kh_at_last) begin
        kh_nx = kh + 2'd1;
      end else begin
        kh_nx = '0;
        if (!tw_at_last) begin
          tw_nx = tile_w + TILE_CNT_WIDTH'(1);
        end else begin
          tw_nx = '0;
          if (!th_at_last) begin
            th_nx = tile_h + TILE_CNT_WIDTH'(1);
          end else begin
            th_nx = '0;
          end
        end
      end
    end
  end

  // Capture the job descriptor when a job is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kh_last_q <= '0;
      kw_last_q <= '0;
      th_last_q <= '0;
      tw_last_q <= '0;
      ih_full_q <= '0;
      iw_full_q <= '0;
      ih_edge_q <= '0;
      iw_edge_q <= '0;
      ic_last   <= '0;
    end else if (accept) begin
      kh_last_q <= cfg_kh_last;
      kw_last_q <= cfg_kw_last;
      th_last_q <= cfg_th_last;
      tw_last_q <= cfg_tw_last;
      ih_full_q <= cfg_ih_last_full;
      iw_full_q <= cfg_iw_last_full;
      ih_edge_q <= cfg_ih_last_edge;
      iw_edge_q <= cfg_iw_last_edge;
      ic_last   <= cfg_ic_last;
    end
  end

  // Position counters and first-pass-of-tile flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kh        <= '0;
      kw        <= '0;
      tile_h    <= '0;
      tile_w    <= '0;
      acc_clear <= 1'b0;
    end else if (accept) begin
      kh        <= '0;
      kw        <= '0;
      tile_h    <= '0;
      tile_w    <= '0;
      acc_clear <= 1'b1;
    end else if (advance) begin
      kh        <= kh_nx;
      kw        <= kw_nx;
      tile_h    <= th_nx;
      tile_w    <= tw_nx;
      acc_clear <= (kh_nx == 2'd0) && (kw_nx == 2'd0);
    end
  end

  // Tile extent: the last tile row/column may be partial and uses the edge extent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ih_low_last <= '0;
      iw_low_last <= '0;
    end else if (accept) begin
      ih_low_last <= (cfg_th_last == '0) ? cfg_ih_last_edge : cfg_ih_last_full;
      iw_low_last <= (cfg_tw_last == '0) ? cfg_iw_last_edge : cfg_iw_last_full;
    end else if (advance) begin
      ih_low_last <= (th_nx == th_last_q) ? ih_edge_q : ih_full_q;
      iw_low_last <= (tw_nx == tw_last_q) ? iw_edge_q : iw_full_q;
    end
  end

endmodule

// File: tb/tb_unroll_oc_sched.sv
// Testbench for unroll_oc_sched: scenario tasks driving jobs, with the
// expected pass sequence derived arithmetically from the job descriptor.
module tb_unroll_oc_sched;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_ic_last;
  logic [1:0] cfg_kh_last;
  logic [1:0] cfg_kw_last;
  logic [3:0] cfg_th_last;
  logic [3:0] cfg_tw_last;
  logic [4:0] cfg_ih_last_full;
  logic [4:0] cfg_iw_last_full;
  logic [4:0] cfg_ih_last_edge;
  logic [4:0] cfg_iw_last_edge;
  logic       abort;
  logic       start;
  logic       done;
  logic [4:0] ic_last;
  logic [4:0] ih_low_start;
  logic [4:0] iw_low_start;
  logic [4:0] ih_low_last;
  logic [4:0] iw_low_last;
  logic [1:0] kh;
  logic [1:0] kw;
  logic [3:0] tile_h;
  logic [3:0] tile_w;
  logic       acc_clear;
  logic       tile_done;
  logic       job_done;
  logic       busy;

  int total;
  int bad;

  unroll_oc_sched #(
    .IC_WIDTH(5), .TILE_SIZE_WIDTH(5), .TILE_CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ic_last(cfg_ic_last), .cfg_kh_last(cfg_kh_last), .cfg_kw_last(cfg_kw_last),
    .cfg_th_last(cfg_th_last), .cfg_tw_last(cfg_tw_last),
    .cfg_ih_last_full(cfg_ih_last_full), .cfg_iw_last_full(cfg_iw_last_full),
    .cfg_ih_last_edge(cfg_ih_last_edge), .cfg_iw_last_edge(cfg_iw_last_edge),
    .abort(abort), .start(start), .done(done), .ic_last(ic_last),
    .ih_low_start(ih_low_start), .iw_low_start(iw_low_start),
    .ih_low_last(ih_low_last), .iw_low_last(iw_low_last),
    .kh(kh), .kw(kw), .tile_h(tile_h), .tile_w(tile_w),
    .acc_clear(acc_clear), .tile_done(tile_done), .job_done(job_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one job from IDLE. Expected pass order is computed from the pass
  // index by mixed-radix decomposition. stop_at >= 0 returns in the ISSUE
  // cycle of that pass; dly_fixed > 0 fixes the start-to-done delay; noise
  // pulses cfg_valid with random fields while the job is busy.
  task automatic run_job(input logic [4:0] ic, input logic [1:0] khl, input logic [1:0] kwl,
                         input logic [3:0] thl, input logic [3:0] twl,
                         input logic [4:0] fh, input logic [4:0] fw,
                         input logic [4:0] eh, input logic [4:0] ew,
                         input int stop_at, input int dly_fixed, input bit noise);
    int nkw, nkh, ntw, nth, npass;
    int ekw, ekh, etw, eth, dly;
    logic [4:0] eih, eiw;
    bit e_tile, e_job, e_clr;
    nkw = int'(kwl) + 1; nkh = int'(khl) + 1; ntw = int'(twl) + 1; nth = int'(thl) + 1;
    npass = nkw * nkh * ntw * nth;
    total++;
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_ready_idle: got %0b want 1", cfg_ready); end
    cfg_ic_last = ic; cfg_kh_last = khl; cfg_kw_last = kwl;
    cfg_th_last = thl; cfg_tw_last = twl;
    cfg_ih_last_full = fh; cfg_iw_last_full = fw;
    cfg_ih_last_edge = eh; cfg_iw_last_edge = ew;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int p = 0; p < npass; p++) begin
      ekw = p % nkw;
      ekh = (p / nkw) % nkh;
      etw = (p / (nkw * nkh)) % ntw;
      eth = p / (nkw * nkh * ntw);
      eih = (eth == nth - 1) ? eh : fh;
      eiw = (etw == ntw - 1) ? ew : fw;
      e_clr  = (ekh == 0) && (ekw == 0);
      e_tile = (ekh == nkh - 1) && (ekw == nkw - 1);
      e_job  = (p == npass - 1);
      total++;
      if (start !== 1'b1 || busy !== 1'b1) begin
        bad++; $display("FAIL start_pass p%0d: got start=%0b busy=%0b want 1 1", p, start, busy);
      end
      total++;
      if (kh !== 2'(ekh) || kw !== 2'(ekw) || tile_h !== 4'(eth) || tile_w !== 4'(etw)) begin
        bad++;
        $display("FAIL position p%0d: got kh=%0d kw=%0d th=%0d tw=%0d want %0d %0d %0d %0d",
                 p, kh, kw, tile_h, tile_w, ekh, ekw, eth, etw);
      end
      total++;
      if (ih_low_last !== eih || iw_low_last !== eiw) begin
        bad++;
        $display("FAIL extent p%0d: got ih=%0d iw=%0d want %0d %0d", p, ih_low_last, iw_low_last, eih, eiw);
      end
      total++;
      if (ic_last !== ic || ih_low_start !== 5'd0 || iw_low_start !== 5'd0) begin
        bad++;
        $display("FAIL ic_start p%0d: got ic=%0d ihs=%0d iws=%0d want %0d 0 0", p, ic_last, ih_low_start, iw_low_start, ic);
      end
      total++;
      if (acc_clear !== e_clr) begin
        bad++; $display("FAIL acc_clear p%0d: got %0b want %0b", p, acc_clear, e_clr);
      end
      if (p == stop_at) return;
      dly = (dly_fixed > 0) ? dly_fixed : int'($urandom_range(1, 5));
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        cfg_valid = 1'b0;
        total++;
        if (start !== 1'b0 || kh !== 2'(ekh) || kw !== 2'(ekw) || tile_w !== 4'(etw) || ic_last !== ic) begin
          bad++;
          $display("FAIL wait_stable p%0d: got start=%0b kh=%0d kw=%0d tw=%0d ic=%0d want 0 %0d %0d %0d %0d",
                   p, start, kh, kw, tile_w, ic_last, ekh, ekw, etw, ic);
        end
        if (noise && i == 0) begin
          cfg_ic_last = 5'($urandom); cfg_kh_last = 2'($urandom_range(0, 2));
          cfg_kw_last = 2'($urandom_range(0, 2)); cfg_th_last = 4'($urandom);
          cfg_tw_last = 4'($urandom); cfg_ih_last_full = 5'($urandom);
          cfg_iw_last_full = 5'($urandom); cfg_ih_last_edge = 5'($urandom);
          cfg_iw_last_edge = 5'($urandom);
          cfg_valid = 1'b1;
        end
      end
      cfg_valid = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      total++;
      if (tile_done !== e_tile || job_done !== e_job || start !== 1'b0) begin
        bad++;
        $display("FAIL next_events p%0d: got tile_done=%0b job_done=%0b start=%0b want %0b %0b 0",
                 p, tile_done, job_done, start, e_tile, e_job);
      end
      @(negedge clk);
      if (e_job) begin
        total++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
          bad++;
          $display("FAIL job_end: got cfg_ready=%0b busy=%0b start=%0b want 1 0 0", cfg_ready, busy, start);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || tile_done !== 1'b0 ||
        job_done !== 1'b0 || acc_clear !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%0b busy=%0b start=%0b td=%0b jd=%0b clr=%0b want 1 0 0 0 0 0",
               cfg_ready, busy, start, tile_done, job_done, acc_clear);
    end
    total++;
    if (kh !== 2'd0 || kw !== 2'd0 || tile_h !== 4'd0 || tile_w !== 4'd0 || ic_last !== 5'd0 ||
        ih_low_last !== 5'd0 || iw_low_last !== 5'd0) begin
      bad++;
      $display("FAIL reset_params: got kh=%0d kw=%0d th=%0d tw=%0d ic=%0d ih=%0d iw=%0d want all 0",
               kh, kw, tile_h, tile_w, ic_last, ih_low_last, iw_low_last);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_job(5'd3, 2'd2, 2'd2, 4'd0, 4'd0, 5'd29, 5'd29, 5'd29, 5'd29, -1, 50, 1'b0);
  endtask

  task automatic test_tile_grid();
    run_job(5'd17, 2'd0, 2'd0, 4'd1, 4'd2, 5'd31, 5'd31, 5'd7, 5'd7, -1, 0, 1'b0);
  endtask

  task automatic test_done_edge();
    cfg_ic_last = 5'd9; cfg_kh_last = 2'd0; cfg_kw_last = 2'd0;
    cfg_th_last = 4'd0; cfg_tw_last = 4'd1;
    cfg_ih_last_full = 5'd20; cfg_iw_last_full = 5'd21;
    cfg_ih_last_edge = 5'd4; cfg_iw_last_edge = 5'd5;
    cfg_valid = 1'b1;
    done = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    total++;
    if (start !== 1'b1) begin bad++; $display("FAIL edge_start0: got %0b want 1", start); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (start !== 1'b0 || tile_done !== 1'b0 || busy !== 1'b1 || tile_w !== 4'd0) begin
        bad++;
        $display("FAIL edge_hold c%0d: got start=%0b td=%0b busy=%0b tw=%0d want 0 0 1 0",
                 i, start, tile_done, busy, tile_w);
      end
      if (i == 2) done = 1'b0;
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    total++;
    if (tile_done !== 1'b1 || job_done !== 1'b0) begin
      bad++; $display("FAIL edge_next: got td=%0b jd=%0b want 1 0", tile_done, job_done);
    end
    @(negedge clk);
    total++;
    if (start !== 1'b1 || tile_w !== 4'd1 || iw_low_last !== 5'd5 || ih_low_last !== 5'd4) begin
      bad++;
      $display("FAIL edge_restart: got start=%0b tw=%0d iw=%0d ih=%0d want 1 1 5 4",
               start, tile_w, iw_low_last, ih_low_last);
    end
    repeat (2) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    total++;
    if (tile_done !== 1'b1 || job_done !== 1'b1) begin
      bad++; $display("FAIL edge_final: got td=%0b jd=%0b want 1 1", tile_done, job_done);
    end
    @(negedge clk);
    total++;
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL edge_ready: got %0b want 1", cfg_ready); end
  endtask

  task automatic test_abort();
    run_job(5'd6, 2'd2, 2'd2, 4'd0, 4'd0, 5'd10, 5'd11, 5'd12, 5'd13, 3, 0, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || tile_done !== 1'b0 || job_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: got rdy=%0b busy=%0b start=%0b td=%0b jd=%0b want 1 0 0 0 0",
               cfg_ready, busy, start, tile_done, job_done);
    end
    abort = 1'b1;
    cfg_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cfg_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || start !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_prio: got busy=%0b start=%0b rdy=%0b want 0 0 1", busy, start, cfg_ready);
    end
    run_job(5'd2, 2'd1, 2'd2, 4'd0, 4'd0, 5'd8, 5'd9, 5'd3, 5'd4, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    run_job(5'd11, 2'd0, 2'd2, 4'd1, 4'd1, 5'd15, 5'd16, 5'd2, 5'd3, 4, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (start !== 1'b0 || busy !== 1'b0 || kh !== 2'd0 || kw !== 2'd0 || tile_h !== 4'd0 ||
        tile_w !== 4'd0 || ic_last !== 5'd0 || acc_clear !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got start=%0b busy=%0b kh=%0d kw=%0d th=%0d tw=%0d ic=%0d clr=%0b want all 0",
               start, busy, kh, kw, tile_h, tile_w, ic_last, acc_clear);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: got rdy=%0b busy=%0b want 1 0", cfg_ready, busy);
    end
  endtask

  task automatic test_cfg_while_busy();
    run_job(5'd3, 2'd2, 2'd2, 4'd0, 4'd1, 5'd29, 5'd30, 5'd6, 5'd7, -1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) begin
      run_job(5'($urandom), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
              4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
              5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              -1, 0, 1'($urandom));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    cfg_valid = 1'b0;
    abort = 1'b0;
    done = 1'b0;
    cfg_ic_last = '0; cfg_kh_last = '0; cfg_kw_last = '0;
    cfg_th_last = '0; cfg_tw_last = '0;
    cfg_ih_last_full = '0; cfg_iw_last_full = '0;
    cfg_ih_last_edge = '0; cfg_iw_last_edge = '0;
    test_reset();
    test_basic();
    test_tile_grid();
    test_done_edge();
    test_abort();
    test_reset_mid_job();
    test_cfg_while_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
